// File: rtl/contador_pkg.sv
// Shared encodings and helpers for the parametrised pop counter bank.
package contador_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Number of bits needed to index n items, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_param_pop_counter_cell.sv
// One event counter with wrap or saturate behaviour and a sticky overflow flag.
module pop_counter_cell
  import contador_pkg::*;
#(
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned SAT_MODE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count pops; a clear restarts at 0, or 1 if a pop lands in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        ovf <= 1'b1;
        cnt <= (SAT_MODE == MODE_SAT) ? CNT_MAX : '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/contador_param.sv
// Bank of per-FIFO pop counters with a one-cycle registered readback port.
module contador_param
  import contador_pkg::*;
#(
  parameter  int unsigned NUM_CH      = 5,
  parameter  int unsigned CNT_W       = 5,
  parameter  int unsigned SAT_MODE    = MODE_WRAP,
  parameter  int unsigned CLR_ON_READ = 0,
  localparam int unsigned IDX_W       = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] pop,
  input  logic              idle,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  output logic              valid,
  output logic [CNT_W-1:0]  data_out,
  output logic              data_ovf,
  output logic              err
);

  logic [CNT_W-1:0]  cnt_arr [NUM_CH];
  logic [NUM_CH-1:0] ovf_arr;
  logic [NUM_CH-1:0] clr_vec;
  logic              in_range;
  logic              grant;
  logic              bad_req;
  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_ovf;

  // Grant decode and readback mux of the pre-update counter contents.
  always_comb begin
    in_range = (32'(idx) < NUM_CH);
    grant    = req & idle & in_range;
    bad_req  = req & idle & ~in_range;
    rd_cnt   = '0;
    rd_ovf   = 1'b0;
    clr_vec  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(idx) == i) begin
        rd_cnt     = cnt_arr[i];
        rd_ovf     = ovf_arr[i];
        clr_vec[i] = grant & (CLR_ON_READ != 0);
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_cell
    pop_counter_cell #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .inc   (pop[g]),
      .clr   (clr_vec[g]),
      .cnt   (cnt_arr[g]),
      .ovf   (ovf_arr[g])
    );
  end

  // Registered read stage; data holds between granted reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      data_out <= '0;
      data_ovf <= 1'b0;
      err      <= 1'b0;
    end else begin
      valid <= grant;
      err   <= bad_req;
      if (grant) begin
        data_out <= rd_cnt;
        data_ovf <= rd_ovf;
      end
    end
  end

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param: wrap, saturate and clear-on-read variants.
module tb_contador_param;

  localparam int NCFG = 3;
  localparam int NCH  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] pop;
  logic       idle;
  logic       req;
  logic [2:0] idx;

  logic [NCFG-1:0]      valid_v;
  logic [NCFG-1:0][4:0] data_v;
  logic [NCFG-1:0]      ovf_v;
  logic [NCFG-1:0]      err_v;

  int passes = 0;
  int checks = 0;

  // Reference state: 0 = wrap, 1 = saturate, 2 = wrap with clear-on-read.
  int m_cnt [NCFG][NCH];
  bit m_ovf [NCFG][NCH];
  int e_data [NCFG];
  bit e_valid [NCFG];
  bit e_ovf [NCFG];
  bit e_err [NCFG];
  bit model_ok = 1'b0;

  always #5 clk = ~clk;

  contador_param u_wrap (
    .clk(clk), .reset(reset), .pop(pop), .idle(idle), .req(req), .idx(idx),
    .valid(valid_v[0]), .data_out(data_v[0]), .data_ovf(ovf_v[0]), .err(err_v[0])
  );

  contador_param #(.SAT_MODE(1)) u_sat (
    .clk(clk), .reset(reset), .pop(pop), .idle(idle), .req(req), .idx(idx),
    .valid(valid_v[1]), .data_out(data_v[1]), .data_ovf(ovf_v[1]), .err(err_v[1])
  );

  contador_param #(.CLR_ON_READ(1)) u_clr (
    .clk(clk), .reset(reset), .pop(pop), .idle(idle), .req(req), .idx(idx),
    .valid(valid_v[2]), .data_out(data_v[2]), .data_ovf(ovf_v[2]), .err(err_v[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else
      passes++;
  endtask

  // Reference behaviour evaluated once per clock edge from the sampled inputs.
  always @(posedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      if (reset) begin
        for (int i = 0; i < NCH; i++) begin
          m_cnt[c][i] = 0;
          m_ovf[c][i] = 1'b0;
        end
        e_valid[c] = 1'b0;
        e_data[c]  = 0;
        e_ovf[c]   = 1'b0;
        e_err[c]   = 1'b0;
      end else begin
        bit g;
        g = req && idle && (int'(idx) < NCH);
        e_valid[c] = g;
        e_err[c]   = req && idle && (int'(idx) >= NCH);
        if (g) begin
          e_data[c] = m_cnt[c][idx];
          e_ovf[c]  = m_ovf[c][idx];
        end
        for (int i = 0; i < NCH; i++) begin
          if (c == 2 && g && int'(idx) == i) begin
            m_cnt[c][i] = pop[i] ? 1 : 0;
            m_ovf[c][i] = 1'b0;
          end else if (pop[i]) begin
            if (m_cnt[c][i] == 31) begin
              m_ovf[c][i] = 1'b1;
              m_cnt[c][i] = (c == 1) ? 31 : 0;
            end else begin
              m_cnt[c][i] = m_cnt[c][i] + 1;
            end
          end
        end
      end
    end
    if (reset) model_ok = 1'b1;
  end

  // Every-cycle comparison of all three instances against the reference.
  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      for (int c = 0; c < NCFG; c++) begin
        chk($sformatf("cyc_valid[%0d]", c), 32'(valid_v[c]), 32'(e_valid[c]));
        chk($sformatf("cyc_err[%0d]", c), 32'(err_v[c]), 32'(e_err[c]));
        chk($sformatf("cyc_data[%0d]", c), 32'(data_v[c]), 32'(e_data[c]));
        chk($sformatf("cyc_ovf[%0d]", c), 32'(ovf_v[c]), 32'(e_ovf[c]));
      end
    end
  end

  task automatic step(input logic [4:0] p, input logic r, input logic i, input logic [2:0] x);
    pop  = p;
    req  = r;
    idle = i;
    idx  = x;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    pop = '0; req = 1'b0; idle = 1'b0; idx = '0;
    @(negedge clk);
    step(5'h00, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    chk("rst_valid", 32'(valid_v[0]), 32'd0);
    chk("rst_data", 32'(data_v[0]), 32'd0);
    chk("rst_err", 32'(err_v[0]), 32'd0);

    // Three pops on channel 2, then read it and two untouched channels.
    repeat (3) step(5'b00100, 1'b0, 1'b1, 3'd0);
    step(5'h00, 1'b1, 1'b1, 3'd2);
    chk("ch2_valid", 32'(valid_v[0]), 32'd1);
    chk("ch2_data", 32'(data_v[0]), 32'd3);
    chk("ch2_ovf", 32'(ovf_v[0]), 32'd0);
    step(5'h00, 1'b1, 1'b1, 3'd0);
    chk("ch0_zero", 32'(data_v[0]), 32'd0);
    step(5'h00, 1'b1, 1'b1, 3'd4);
    chk("ch4_zero", 32'(data_v[0]), 32'd0);

    // 33 pops on channel 0: wrap ends at 1, saturate holds at 31.
    repeat (33) step(5'b00001, 1'b0, 1'b1, 3'd0);
    step(5'h00, 1'b1, 1'b1, 3'd0);
    chk("wrap_data", 32'(data_v[0]), 32'd1);
    chk("wrap_ovf", 32'(ovf_v[0]), 32'd1);
    chk("sat_data", 32'(data_v[1]), 32'd31);
    chk("sat_ovf", 32'(ovf_v[1]), 32'd1);

    // Request while busy is dropped; out-of-range index flags an error pulse.
    step(5'h00, 1'b1, 1'b0, 3'd1);
    chk("busy_valid", 32'(valid_v[0]), 32'd0);
    chk("busy_err", 32'(err_v[0]), 32'd0);
    chk("busy_hold", 32'(data_v[0]), 32'd1);
    step(5'h00, 1'b1, 1'b1, 3'd6);
    chk("oor_valid", 32'(valid_v[0]), 32'd0);
    chk("oor_err", 32'(err_v[0]), 32'd1);
    step(5'h00, 1'b0, 1'b1, 3'd0);
    chk("oor_err_drop", 32'(err_v[0]), 32'd0);

    // Clear-on-read of channel 4 at 7 with a concurrent pop.
    repeat (7) step(5'b10000, 1'b0, 1'b1, 3'd0);
    step(5'b10000, 1'b1, 1'b1, 3'd4);
    chk("clr_first", 32'(data_v[2]), 32'd7);
    step(5'h00, 1'b0, 1'b1, 3'd0);
    step(5'h00, 1'b1, 1'b1, 3'd4);
    chk("clr_second", 32'(data_v[2]), 32'd1);
    chk("clr_ovf", 32'(ovf_v[2]), 32'd0);
    chk("noclr_second", 32'(data_v[0]), 32'd8);

    // Fresh start, all lines pop 4 times, back-to-back reads of every channel.
    reset = 1'b1;
    step(5'h00, 1'b0, 1'b1, 3'd0);
    reset = 1'b0;
    repeat (4) step(5'h1f, 1'b0, 1'b1, 3'd0);
    for (int k = 0; k < NCH; k++) begin
      step(5'h00, 1'b1, 1'b1, 3'(k));
      chk($sformatf("b2b_valid%0d", k), 32'(valid_v[2]), 32'd1);
      chk($sformatf("b2b_data%0d", k), 32'(data_v[1]), 32'd4);
    end

    // Reset beats a granted read and active pops.
    reset = 1'b1;
    step(5'h1f, 1'b1, 1'b1, 3'd0);
    reset = 1'b0;
    chk("rst2_valid", 32'(valid_v[0]), 32'd0);
    chk("rst2_data", 32'(data_v[0]), 32'd0);
    for (int k = 0; k < NCH; k++) begin
      step(5'h00, 1'b1, 1'b1, 3'(k));
      chk($sformatf("rst2_ch%0d", k), 32'(data_v[0]), 32'd0);
    end
    step(5'h00, 1'b0, 1'b1, 3'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
